// File: rtl/watchdog_supervisor_pkg.sv
// wd_sup_pkg: shared FSM encoding and timer sizing for watchdog_supervisor.
package wd_sup_pkg;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    MUTE  = 3'd2,
    RESET = 3'd3,
    GRACE = 3'd4,
    FAULT = 3'd5
  } state_t;
  function automatic int max3(input int a, input int b, input int c);
    return a > b ? (a > c ? a : c) : (b > c ? b : c);
  endfunction
  localparam int TMR_W = $clog2(max3(16, 32, 256) + 1);
endpackage

// File: rtl/wd_hb_aggregator.sv
// wd_hb_aggregator: collects per-client liveness into a single registered heartbeat pulse.
module wd_hb_aggregator #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [N-1:0] client_alive,
  output logic         hb_pulse
);
  logic [N-1:0] seen_q, seen_d;
  logic         hb_d;
  logic         full;
  assign full = &seen_q;
  // Pulses landing on the clearing edge seed the next round.
  always_comb begin
    seen_d = clr ? '0 : !en ? seen_q : full ? client_alive : seen_q | client_alive;
    hb_d   = !clr && en && full;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      seen_q   <= '0;
      hb_pulse <= 1'b0;
    end else begin
      seen_q   <= seen_d;
      hb_pulse <= hb_d;
    end
  end
endmodule

// File: rtl/watchdog_supervisor.sv
// watchdog_supervisor: arms the watchdog, aggregates heartbeats, sequences recovery; WD_SUP_EVENT_CNT_EN adds recovery_events.
module watchdog_supervisor
  import wd_sup_pkg::*;
#(
  parameter int N_CLIENTS    = 3,
  parameter int MUTE_CYCLES  = 16,
  parameter int RESET_CYCLES = 32,
  parameter int GRACE_CYCLES = 256,
  parameter int MAX_RETRIES  = 3
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               sys_enable,
  input  logic [N_CLIENTS-1:0]               client_alive,
  input  logic                               wd_force_reset,
  input  logic                               clear_fault,
  output logic                               wd_enable,
  output logic                               wd_heartbeat,
  output logic                               rf_mute,
  output logic                               subsys_reset,
  output logic                               fault_latched,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count,
  output logic [2:0]                         state
`ifdef WD_SUP_EVENT_CNT_EN
  ,output logic [15:0]                       recovery_events
`endif
);
  localparam int TW = $clog2(max3(MUTE_CYCLES, RESET_CYCLES, GRACE_CYCLES) + 1);
  localparam int RW = $clog2(MAX_RETRIES + 1);
  state_t          state_q, state_d;
  logic [TW-1:0]   tmr_q, tmr_d, dwell;
  logic [RW-1:0]   rc_q, rc_d, rc_eff;
  logic            hb;
  logic            sat;
  assign dwell = state_q == MUTE  ? TW'(MUTE_CYCLES - 1) :
                 state_q == RESET ? TW'(RESET_CYCLES - 1) : TW'(GRACE_CYCLES - 1);
  // A heartbeat on the current cycle already proves recovery, so it wins over a stale count.
  assign rc_eff = hb ? '0 : rc_q;
  assign sat    = rc_eff == RW'(MAX_RETRIES);
  always_comb begin
    state_d = state_q;
    rc_d    = rc_q;
    if (!sys_enable && state_q != FAULT) state_d = IDLE;
    else begin
      case (state_q)
        IDLE:  state_d = ARMED;
        ARMED: begin
          rc_d = rc_eff;
          if (wd_force_reset) begin
            state_d = sat ? FAULT : MUTE;
            rc_d    = sat ? rc_eff : rc_eff + 1'b1;
          end
        end
        MUTE, RESET, GRACE:
          if (tmr_q == dwell) state_d = state_q == GRACE ? ARMED : state_t'(state_q + 3'd1);
        FAULT: begin
          if (clear_fault) begin
            state_d = IDLE;
            rc_d    = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    tmr_d = (state_d == state_q && (state_q == MUTE || state_q == RESET || state_q == GRACE)) ?
            tmr_q + 1'b1 : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      rc_q    <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      rc_q    <= rc_d;
    end
  end
  wd_hb_aggregator #(.N(N_CLIENTS)) u_hb (
    .clk          (clk),
    .rst          (rst),
    .clr          (state_d != ARMED),
    .en           (state_q == ARMED),
    .client_alive (client_alive),
    .hb_pulse     (hb)
  );
  assign wd_enable     = state_q == ARMED;
  assign wd_heartbeat  = hb;
  assign rf_mute       = state_q != ARMED;
  assign subsys_reset  = state_q == RESET;
  assign fault_latched = state_q == FAULT;
  assign retry_count   = rc_q;
  assign state         = state_q;
`ifdef WD_SUP_EVENT_CNT_EN
  logic [15:0] ev_q;
  always_ff @(posedge clk) begin
    if (rst) ev_q <= '0;
    else if (state_q == ARMED && (state_d == MUTE || state_d == FAULT) && ev_q != 16'hFFFF)
      ev_q <= ev_q + 16'd1;
  end
  assign recovery_events = ev_q;
`endif
endmodule

// File: doc/watchdog_supervisor.md
Name: watchdog_supervisor

Overview:
- Sequences the `watchdog_timer` in the AM radio FPGA and owns all of its inputs.
- Aggregates liveness pulses from N client subsystems (SCPI command handler, NCO/DDS, modulator) into one watchdog heartbeat.
- On watchdog `force_reset`, runs a recovery sequence: mute RF, pulse a subsystem reset, wait a grace period, re-arm.
- Latches a hard fault after repeated failed recoveries.

Parameters:
- N_CLIENTS, 3, number of client liveness inputs.
- MUTE_CYCLES, 16, cycles RF is muted before subsystem reset asserts.
- RESET_CYCLES, 32, cycles `subsys_reset` is held.
- GRACE_CYCLES, 256, cycles after reset before the watchdog is re-armed.
- MAX_RETRIES, 3, failed recoveries tolerated before FAULT.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- sys_enable  in  1  global run enable
- client_alive  in  N_CLIENTS  per-client single-cycle liveness pulses
- wd_force_reset  in  1  `force_reset` from `watchdog_timer`
- clear_fault  in  1  single-cycle pulse; clears FAULT
- wd_enable  out  1  to `watchdog_timer` enable
- wd_heartbeat  out  1  single-cycle pulse to `watchdog_timer` heartbeat
- rf_mute  out  1  forces RF output to zero
- subsys_reset  out  1  active-high reset to client subsystems
- fault_latched  out  1  high in FAULT
- retry_count  out  $clog2(MAX_RETRIES+1)  consecutive failed recoveries
- state  out  3  current FSM state encoding (debug)

Behaviour:
- Clock and reset: one clock `clk`. `rst` is synchronous, active-high, and has highest priority.
- Reset values:
  - state = IDLE
  - wd_enable = 0, wd_heartbeat = 0, subsys_reset = 0, fault_latched = 0
  - rf_mute = 1
  - retry_count = 0
  - seen vector = 0, timer = 0
- States:
  - IDLE
  - ARMED
  - MUTE
  - RESET
  - GRACE
  - FAULT
- Priority, evaluated per cycle: `rst` > `sys_enable` = 0 > `clear_fault` > `wd_force_reset` > timer expiry.
- `sys_enable` = 0 in any state except FAULT: go to IDLE next cycle; timer and seen vector cleared. FAULT ignores `sys_enable`.
- IDLE:
  - Outputs: rf_mute = 1, wd_enable = 0, subsys_reset = 0.
  - Go to ARMED the cycle after `sys_enable` = 1.
- ARMED:
  - Outputs: wd_enable = 1, rf_mute = 0.
  - Each `client_alive[i]` pulse sets `seen[i]`.
  - When `seen` is all ones at a clock edge, `wd_heartbeat` pulses for exactly 1 cycle on the next cycle, `seen` clears to 0, and `retry_count` clears to 0.
  - Pulses arriving in the same cycle as the clear count toward the next round.
  - Heartbeat latency from the last missing pulse to `wd_heartbeat` is 2 cycles.
  - `wd_force_reset` = 1: if `retry_count` == MAX_RETRIES, go to FAULT; otherwise `retry_count` +1 and go to MUTE.
- MUTE:
  - Outputs: rf_mute = 1, wd_enable = 0.
  - Timer counts MUTE_CYCLES, then go to RESET.
- RESET:
  - Outputs: rf_mute = 1, subsys_reset = 1, wd_enable = 0.
  - Lasts RESET_CYCLES, then go to GRACE.
- GRACE:
  - Outputs: rf_mute = 1, subsys_reset = 0, wd_enable = 0.
  - `client_alive` is ignored.
  - Lasts GRACE_CYCLES, then go to ARMED with `seen` = 0.
- FAULT:
  - Outputs: rf_mute = 1, wd_enable = 0, fault_latched = 1.
  - `clear_fault` goes to IDLE and sets `retry_count` = 0.
- `wd_force_reset` outside ARMED is ignored. The watchdog is disabled in those states, so any assertion there is stale.
- All dwell timers are exact: state occupancy equals the parameter value in cycles.
- The timer resets on every state entry.
- `retry_count` saturates at MAX_RETRIES and never wraps.
- `wd_heartbeat` is never high outside ARMED.

Optional Feature:
- Macro: WD_SUP_EVENT_CNT_EN.
- When defined:
  - Adds output `recovery_events` [15:0]: increments on each ARMED→MUTE or ARMED→FAULT transition and saturates at 0xFFFF.
  - Cleared only by `rst`.
- When undefined: the port and the counter are absent, and all other behaviour is identical.

Decomposition:
- Package `wd_sup_pkg` holds:
  - the `state_t` enum (IDLE=0, ARMED=1, MUTE=2, RESET=3, GRACE=4, FAULT=5)
  - the timer width constant `TMR_W = $clog2(max(MUTE_CYCLES, RESET_CYCLES, GRACE_CYCLES)+1)`
- Sub-module `wd_hb_aggregator`:
  - Contains the `seen` vector and the registered `wd_heartbeat` pulse generation.
  - Inputs: `clk`, `rst`, `clr`, `en`, `client_alive`.
  - Output: `hb_pulse`.

Test Plan:
1. `rst` then `sys_enable` = 1 → ARMED on the 2nd cycle, wd_enable = 1, rf_mute = 0; all other outputs at reset values.
2. Pulse `client_alive` 3'b001, 3'b010, 3'b100 on cycles 10, 12, 14 → `wd_heartbeat` high only at cycle 16; `seen` = 0 after.
3. `wd_force_reset` in ARMED:
   - rf_mute = 1 for 16+32+256 cycles.
   - subsys_reset high exactly 32 cycles starting 16 cycles after entry.
   - ARMED is re-entered after 304 cycles; retry_count = 1.
4. Four `wd_force_reset` events with no heartbeat in between → 4th event enters FAULT with fault_latched = 1 and retry_count = 3. `clear_fault` → IDLE with retry_count = 0.
5. Drop `sys_enable` mid-RESET → IDLE next cycle with subsys_reset = 0 and rf_mute = 1. Assert `rst` in FAULT → IDLE with fault_latched = 0.
6. With WD_SUP_EVENT_CNT_EN defined: run scenario 4 → recovery_events = 4.
